// File: rtl/gray_conv_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gray_conv_rr_scheduler
//  Description : Shares one 4-bit binary-to-gray converter between NREQ
//                requesters. A round-robin arbiter grants one requester at a
//                time. The grant captures that requester's binary value. One
//                CONV cycle drives the converter's enable, and the result is
//                registered into a single valid/ready output slot.
//  Ports       : clk, rst           - clock / synchronous active-high reset
//                req_valid/req_bin  - per-requester request and 4-bit value
//                req_ready          - one-hot grant (combinational)
//                out_valid/out_gray - registered result slot
//                out_id             - requester index that owns out_gray
//                out_ready          - downstream accept
//                conv_count         - results accepted downstream (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*4-1:0] req_bin,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [3:0]        out_gray,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready,
    output logic [CNTW-1:0]   conv_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_conv = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_last_grant;
    logic [3:0]      r_cap_bin;
    logic [IDW-1:0]  r_cap_id;
    logic            r_out_valid;
    logic [3:0]      r_out_gray;
    logic [IDW-1:0]  r_out_id;
    logic [CNTW-1:0] r_conv_count;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic            w_grant_en;
    logic            w_grant;
    logic [3:0]      w_sel_bin;
    logic            w_enb;
    logic [3:0]      w_conv_y;

    // Round-robin search: start one past the last accepted requester and
    // wrap around so the last winner is considered last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_last_grant) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // A grant may only be issued when the result slot is free or is being
    // emptied this very cycle; never during CONV and never under reset.
    assign w_grant_en = !rst && ((r_state == c_st_idle) ||
                                 ((r_state == c_st_hold) && out_ready));
    assign w_grant    = w_grant_en && w_found;
    assign req_ready  = w_grant ? (NREQ'(1) << w_win) : '0;
    assign w_sel_bin  = req_bin[{w_win, 2'b00} +: 4];

    // Shared converter: output forced to zero whenever it is not enabled.
    assign w_enb    = (r_state == c_st_conv);
    assign w_conv_y = w_enb ? {r_cap_bin[3],
                               r_cap_bin[3] ^ r_cap_bin[2],
                               r_cap_bin[2] ^ r_cap_bin[1],
                               r_cap_bin[1] ^ r_cap_bin[0]} : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_last_grant <= IDW'(NREQ - 1);
            r_cap_bin    <= '0;
            r_cap_id     <= '0;
            r_out_valid  <= 1'b0;
            r_out_gray   <= '0;
            r_out_id     <= '0;
            r_conv_count <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_conv_count <= r_conv_count + CNTW'(1);
            end
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_cap_bin    <= w_sel_bin;
                        r_cap_id     <= w_win;
                        r_last_grant <= w_win;
                        r_state      <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    r_out_gray  <= w_conv_y;
                    r_out_id    <= r_cap_id;
                    r_out_valid <= 1'b1;
                    r_state     <= c_st_hold;
                end
                c_st_hold: begin
                    if (out_ready) begin
                        // Slot is consumed; refill it from the next winner
                        // in the same cycle when anyone is waiting.
                        r_out_valid <= 1'b0;
                        if (w_grant) begin
                            r_cap_bin    <= w_sel_bin;
                            r_cap_id     <= w_win;
                            r_last_grant <= w_win;
                            r_state      <= c_st_conv;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_gray   = r_out_gray;
    assign out_id     = r_out_id;
    assign conv_count = r_conv_count;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_conv_rr_scheduler
//  Description : Scoreboard bench for gray_conv_rr_scheduler. The driver
//                models requesters that hold their request until accepted.
//                A negedge monitor predicts grants, results and the counter
//                from a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_conv_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 5;

    localparam int P_IDLE = 0;
    localparam int P_CONV = 1;
    localparam int P_HOLD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*4-1:0] req_bin;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [3:0]        out_gray;
    logic [IDW-1:0]    out_id;
    logic              out_ready;
    logic [CNTW-1:0]   conv_count;

    gray_conv_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
        .req_ready(req_ready), .out_valid(out_valid), .out_gray(out_gray),
        .out_id(out_id), .out_ready(out_ready), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] gray;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    int   m_phase = P_IDLE;
    int   m_last  = NREQ - 1;
    int   m_count = 0;
    bit   m_fresh = 1'b1;

    logic [NREQ-1:0] acc_mask = '0;

    // requester model
    logic       rq_valid[NREQ];
    logic [3:0] rq_bin[NREQ];
    int         mode = 0;
    int         sweep_next = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    function automatic logic [3:0] ref_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [NREQ-1:0] mon_exp_rdy;
    int              mon_w;
    bit              mon_opp;
    exp_t            mon_e;

    always @(negedge clk) begin
        mon_exp_rdy = '0;
        mon_w       = -1;
        mon_opp     = !rst && (m_phase == P_IDLE || (m_phase == P_HOLD && out_ready));
        if (mon_opp) begin
            mon_w = rr_pick(req_valid, m_last);
            if (mon_w >= 0) mon_exp_rdy[mon_w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(mon_exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_phase == P_HOLD));
        if (m_phase == P_HOLD) begin
            if (sb_q.size() == 0) begin
                timeout_fail("scoreboard_empty");
            end else begin
                chk("out_id", 32'(out_id), 32'(sb_q[0].id));
                chk("out_gray", 32'(out_gray), 32'(sb_q[0].gray));
            end
        end
        if (m_fresh) begin
            chk("reset_out_gray", 32'(out_gray), 32'd0);
            chk("reset_out_id", 32'(out_id), 32'd0);
        end
        chk("conv_count", 32'(conv_count), 32'(m_count % (1 << CNTW)));

        acc_mask = req_valid & req_ready;
        if (rst) begin
            m_phase = P_IDLE;
            m_last  = NREQ - 1;
            m_count = 0;
            m_fresh = 1'b1;
            sb_q.delete();
        end else begin
            if (m_phase == P_CONV) m_fresh = 1'b0;
            if (m_phase == P_HOLD && out_ready) begin
                void'(sb_q.pop_front());
                m_count++;
            end
            if (mon_w >= 0) begin
                mon_e.id   = mon_w;
                mon_e.gray = ref_gray(req_bin[mon_w*4 +: 4]);
                sb_q.push_back(mon_e);
                m_last  = mon_w;
                m_phase = P_CONV;
            end else if (m_phase == P_CONV) begin
                m_phase = P_HOLD;
            end else if (m_phase == P_HOLD && out_ready) begin
                m_phase = P_IDLE;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = rq_valid[i];
            req_bin[i*4 +: 4]  = rq_bin[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) rq_valid[i] = 1'b0;
        end
        case (mode)
            1: for (int i = 0; i < NREQ; i++) begin
                   if (!rq_valid[i]) begin
                       rq_valid[i] = 1'b1;
                       rq_bin[i]   = 4'($urandom_range(15));
                   end
               end
            2: if (!rq_valid[1] && sweep_next < 16) begin
                   rq_valid[1] = 1'b1;
                   rq_bin[1]   = 4'(sweep_next);
                   sweep_next++;
               end
            3: begin
                   for (int i = 0; i < NREQ; i++) begin
                       if (!rq_valid[i] && $urandom_range(2) == 0) begin
                           rq_valid[i] = 1'b1;
                           rq_bin[i]   = 4'($urandom_range(15));
                       end
                   end
                   out_ready = ($urandom_range(3) != 0);
               end
            default: ;
        endcase
        drive();
    endtask

    task automatic drain(input string name);
        int n;
        mode = 0;
        out_ready = 1'b1;
        n = 0;
        while (n < 60 && !(m_phase == P_IDLE && !rq_valid[0] && !rq_valid[1] &&
                            !rq_valid[2] && !rq_valid[3])) begin
            cycle();
            n++;
        end
        if (n >= 60) timeout_fail(name);
    endtask

    task automatic wait_phase(input int ph, input string name);
        int n;
        n = 0;
        while (n < 40 && m_phase != ph) begin
            cycle();
            n++;
        end
        if (m_phase != ph) timeout_fail(name);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rq_valid[i] = 1'b1;
            rq_bin[i]   = 4'(i);
        end
        drive();
        // reset with all requesters asserting
        repeat (2) cycle();
        rst = 1'b0;

        // round robin with everyone busy
        mode = 1;
        repeat (16) cycle();

        // backpressure: hold the slot for several cycles
        wait_phase(P_HOLD, "wait_hold_bp");
        out_ready = 1'b0;
        repeat (6) cycle();
        out_ready = 1'b1;
        drain("drain_rr");

        // single request from requester 2
        rq_valid[2] = 1'b1;
        rq_bin[2]   = 4'b1011;
        drive();
        repeat (4) cycle();
        drain("drain_single");

        // reset while converting
        mode = 1;
        wait_phase(P_CONV, "wait_conv_rst");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (6) cycle();

        // reset while holding a result
        wait_phase(P_HOLD, "wait_hold_rst");
        out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
        drain("drain_rst");

        // sweep requester 1 through every value from a clean counter
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sweep_next = 0;
        mode = 2;
        repeat (40) cycle();
        drain("drain_sweep");
        chk("sweep_count", 32'(conv_count), 32'd16);

        // random traffic with random backpressure (counter wraps)
        mode = 3;
        repeat (1500) cycle();
        drain("drain_random");
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
